// File: rtl/fifo_dual_drain.sv
// fifo_dual_drain: drains up to two entries per cycle from a dual-ported FIFO
// into a 2-entry in-order staging buffer and presents them on two issue lanes.
// Lane 1 always carries the oldest staged entry; lane 2 retires only together
// with lane 1.
//
// Optional feature macro: DRAIN_STATS_EN adds saturating drain statistics
// counters (stat_dual, stat_single, stat_starve) and their ports.
//
// Timing note: out_ready_1/2 reach fifo_pop_1/2 through combinational logic
// so that a slot freed this cycle can be refilled in the same cycle.
//
// state | meaning
// EMPTY | no staged entries; both lanes invalid
// ONE   | slot0 valid; lane 1 valid
// TWO   | slot0 and slot1 valid; both lanes valid
module fifo_dual_drain #(
  parameter int DW    = 16,
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          fifo_valid_1,
  input  logic          fifo_valid_2,
  input  logic [DW-1:0] fifo_data_1,
  input  logic [DW-1:0] fifo_data_2,
  output logic          fifo_pop_1,
  output logic          fifo_pop_2,
  output logic          out_valid_1,
  output logic [DW-1:0] out_data_1,
  input  logic          out_ready_1,
  output logic          out_valid_2,
  output logic [DW-1:0] out_data_2,
  input  logic          out_ready_2
`ifdef DRAIN_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_dual,
  output logic [CNT_W-1:0] stat_single,
  output logic [CNT_W-1:0] stat_starve
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [DW-1:0] slot0, slot1;
  logic [1:0]    occ, rem, occ_next;
  logic          fire1, fire2;

  assign out_valid_1 = (state != EMPTY);
  assign out_valid_2 = (state == TWO);
  assign out_data_1  = slot0;
  assign out_data_2  = slot1;

  // Fires, remaining count, refill pops and next occupancy
  always_comb begin
    occ        = 2'd0;
    fire1      = 1'b0;
    fire2      = 1'b0;
    rem        = 2'd0;
    fifo_pop_1 = 1'b0;
    fifo_pop_2 = 1'b0;
    occ_next   = 2'd0;
    state_next = state;
    case (state)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    fire1      = out_valid_1 & out_ready_1;
    fire2      = fire1 & out_valid_2 & out_ready_2;
    rem        = occ - {1'b0, fire1} - {1'b0, fire2};
    fifo_pop_1 = rst_n & fifo_valid_1 & (rem <= 2'd1) & ~flush;
    fifo_pop_2 = fifo_pop_1 & fifo_valid_2 & (rem == 2'd0);
    occ_next   = rem + {1'b0, fifo_pop_1} + {1'b0, fifo_pop_2};
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (occ_next)
        2'd1:    state_next = ONE;
        2'd2:    state_next = TWO;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Staging slots: compact on a single retire from TWO, refill behind survivors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (!flush) begin
      if (rem == 2'd1) begin
        if (state == TWO) slot0 <= slot1;
        if (fifo_pop_1)   slot1 <= fifo_data_1;
      end else if (rem == 2'd0) begin
        if (fifo_pop_1) slot0 <= fifo_data_1;
        if (fifo_pop_2) slot1 <= fifo_data_2;
      end
    end
  end

`ifdef DRAIN_STATS_EN
  logic starve;
  assign starve = (state == EMPTY) & ~fifo_valid_1;

  // Saturating drain statistics, cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_dual   <= '0;
      stat_single <= '0;
      stat_starve <= '0;
    end else if (flush) begin
      stat_dual   <= '0;
      stat_single <= '0;
      stat_starve <= '0;
    end else begin
      if (fire2 && stat_dual != '1)            stat_dual   <= stat_dual + CNT_W'(1);
      if (fire1 && !fire2 && stat_single != '1) stat_single <= stat_single + CNT_W'(1);
      if (starve && stat_starve != '1)          stat_starve <= stat_starve + CNT_W'(1);
    end
  end
`endif

  // Handshake invariants
  a_pop2_needs_pop1: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_pop_2 |-> fifo_pop_1);
  a_pop1_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_pop_1 |-> fifo_valid_1);
  a_lane2_needs_lane1: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_2 |-> out_valid_1);

endmodule

// File: doc/fifo_dual_drain.md
Name: fifo_dual_drain

Overview:
- Consumer-side companion of the dual-ported FIFO: drains up to two entries per cycle through the FIFO's linked pop_1/pop_2 output interface.
- Holds them in a 2-entry in-order staging buffer and presents them to two downstream issue lanes, each with a valid/ready handshake.
- Sits between the decode/issue queue and the two execution lanes. Lane 1 always carries the oldest entry.

Parameters:
- DW, 16, data bits per entry.
- CNT_W, 32, width of statistics counters (used only with DRAIN_STATS_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; drives the FIFO's valid_flush in the same cycle
- fifo_valid_1  in  1  FIFO head entry valid
- fifo_valid_2  in  1  FIFO head+1 entry valid
- fifo_data_1  in  DW  FIFO head data
- fifo_data_2  in  DW  FIFO head+1 data
- fifo_pop_1  out  1  pop head
- fifo_pop_2  out  1  pop head+1; never asserted without fifo_pop_1
- out_valid_1  out  1  lane 1 valid (oldest staged entry)
- out_data_1  out  DW  lane 1 data
- out_ready_1  in  1  lane 1 accept
- out_valid_2  out  1  lane 2 valid (second-oldest staged entry)
- out_data_2  out  DW  lane 2 data
- out_ready_2  in  1  lane 2 accept
- stat_dual, stat_single, stat_starve  out  CNT_W each  present only with DRAIN_STATS_EN

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Staging buffer: slot0 (older) and slot1. Occupancy FSM states: EMPTY, ONE, TWO.
- Reset: state EMPTY; slot data 0; out_valid_1=0, out_valid_2=0. fifo_pop_1/2 are forced 0 while rst_n=0.
- Output mapping:
  - out_valid_1 = (state != EMPTY); out_data_1 = slot0.
  - out_valid_2 = (state == TWO); out_data_2 = slot1.
- In-order fire rules:
  - fire1 = out_valid_1 & out_ready_1.
  - fire2 = fire1 & out_valid_2 & out_ready_2.
  - out_ready_2 without out_ready_1 is ignored, so lane 2 never retires before lane 1.
- Remaining count: r = occ - fire1 - fire2, where occ is 0/1/2.
- Refill (combinational, same cycle):
  - fifo_pop_1 = fifo_valid_1 & (r <= 1) & ~flush.
  - fifo_pop_2 = fifo_pop_1 & fifo_valid_2 & (r == 0).
  - The combinational path out_ready -> fifo_pop is accepted and is documented for timing.
- Next state:
  - occ_next = r + fifo_pop_1 + fifo_pop_2. Encode 0 -> EMPTY, 1 -> ONE, 2 -> TWO.
- Slot update:
  - r=1 after fire1 from TWO: slot1 compacts into slot0; popped data_1 (if any) goes to slot1.
  - r=1 with no fire (state ONE held): slot0 holds; popped data_1 goes to slot1.
  - r=0: slot0 <= fifo_data_1, slot1 <= fifo_data_2 (each only if popped).
  - Unpopped/unused slots hold their old value.
- Latency: an entry valid at the FIFO in cycle N appears on out_valid no earlier than cycle N+1. Sustained throughput is 2 entries/cycle when both lanes stay ready.
- Full stage (TWO) with no fires: no pops; the FIFO holds its entries.
- FIFO empty: no pops; staged entries remain valid until accepted.
- Flush: next state EMPTY, pops suppressed, staged entries discarded. Downstream fires in the flush cycle are still accepted but have no effect on the result.
- Reset asserted mid-operation: immediate return to the reset state; staged data lost.
- Invariants (asserted in RTL, disabled during reset):
  - fifo_pop_2 -> fifo_pop_1.
  - fifo_pop_1 -> fifo_valid_1.
  - out_valid_2 -> out_valid_1.

Optional Feature:
- Macro: DRAIN_STATS_EN.
- When defined:
  - Three saturating CNT_W counters, reset to 0 by rst_n and cleared by flush.
  - stat_dual increments on fire2.
  - stat_single increments on fire1 & ~fire2.
  - stat_starve increments when state==EMPTY & ~fifo_valid_1.
- When undefined: counters and their ports are absent; no other behaviour changes.

Test Plan:
- Reset, FIFO holds A,B, both lanes ready: cycle 0 pops both; cycle 1 out A on lane 1 and B on lane 2; both fire.
- Stream A..F with both lanes always ready: pairs (A,B),(C,D),(E,F) retire on consecutive cycles; fifo_pop_2 stays high throughout.
- State TWO holding A,B; out_ready_1=1, out_ready_2=0; FIFO head C: A retires, next cycle lane 1=B, lane 2=C.
- State TWO holding A,B; out_ready_1=0, out_ready_2=1: nothing retires, no pops, A and B hold.
- State ONE holding A; FIFO offers B,C; flush=1: no pops; next cycle EMPTY with out_valid_1=0.
- rst_n pulled low while in TWO: out_valid_1/2 drop to 0 asynchronously; after release, first FIFO entry appears one cycle after its pop. With DRAIN_STATS_EN, all counters read 0.
